dmem_responder: RTL and testbench

- Memory-side responder for the pipeline's data SRAM port, driven by the execute stage (`data_sram_en`/`wen`/`addr`/`wdata`).
- Owns a byte-writable word array with a configurable access latency.
- Raises a stall request while an access is in flight; returns read data to the data-cache/DC stage.
- Used as the data memory in simulation and FPGA builds.

---
 rtl/dmem_responder_pkg.sv | 19 +
 rtl/dmem_responder_if.sv | 41 ++++
 rtl/dmem_bank.sv | 54 +++++
 rtl/dmem_responder.sv | 165 ++++++++++++++++
 tb/tb_dmem_responder.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder.
// Contents:
//   DMEM_AW   - default word-address width
//   WORD_W    - data word width
//   NUM_LANES - byte lanes per word
//   state_e   - responder FSM encoding
package dmem_responder_pkg;

   localparam int unsigned DMEM_AW   = 12;
   localparam int unsigned WORD_W    = 32;
   localparam int unsigned NUM_LANES = 4;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StBusy = 2'd1,
      StDone = 2'd2
   } state_e;

endpackage

// File: rtl/dmem_responder_if.sv
// Data SRAM port between the execute stage and the data memory responder.
// Signals:
//   data_sram_en      requester -> memory  request valid
//   data_sram_wen     requester -> memory  byte write enables, 0 = read
//   data_sram_addr    requester -> memory  byte address
//   data_sram_wdata   requester -> memory  write data, lanes pre-replicated
//   data_sram_rdata   memory -> requester  data of last completed read
//   stallreq_for_mem  memory -> requester  hold the request, stall the pipeline
//   mem_err           memory -> requester  sticky range error
interface dmem_responder_if;
   import dmem_responder_pkg::*;

   logic                 data_sram_en;
   logic [NUM_LANES-1:0] data_sram_wen;
   logic [31:0]          data_sram_addr;
   logic [WORD_W-1:0]    data_sram_wdata;
   logic [WORD_W-1:0]    data_sram_rdata;
   logic                 stallreq_for_mem;
   logic                 mem_err;

   modport master (
      output data_sram_en,
      output data_sram_wen,
      output data_sram_addr,
      output data_sram_wdata,
      input  data_sram_rdata,
      input  stallreq_for_mem,
      input  mem_err
   );

   modport slave (
      input  data_sram_en,
      input  data_sram_wen,
      input  data_sram_addr,
      input  data_sram_wdata,
      output data_sram_rdata,
      output stallreq_for_mem,
      output mem_err
   );

endinterface

// File: rtl/dmem_bank.sv
// Byte-writable 2^AW x 32 word array with a registered read port.
// Ports:
//   clk, rst   clock, synchronous active-high reset (clears read register only)
//   we_i       per-lane write enables
//   re_i       load the read register from the addressed word
//   rd_zero_i  with re_i, load zero instead of the array word
//   idx_i      word index
//   wdata_i    write data
//   rdata_o    read register, holds until the next read
module dmem_bank
   import dmem_responder_pkg::*;
#(
   parameter int unsigned AW = DMEM_AW
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_LANES-1:0] we_i,
   input  logic                 re_i,
   input  logic                 rd_zero_i,
   input  logic [AW-1:0]        idx_i,
   input  logic [WORD_W-1:0]    wdata_i,
   output logic [WORD_W-1:0]    rdata_o
);

   logic [WORD_W-1:0] mem_q [2**AW];
   logic [WORD_W-1:0] rdata_q, rdata_d;

   // Array contents survive reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < int'(NUM_LANES); i++) begin
         if (we_i[i]) begin
            mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
         end
      end
   end

   always_comb begin
      rdata_d = rdata_q;
      if (re_i) begin
         rdata_d = rd_zero_i ? '0 : mem_q[idx_i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data memory responder for the pipeline's data SRAM port. Accepts one
// request at a time, completes it LATENCY clock edges after acceptance and
// asks the pipeline to stall while the access is in flight.
// Parameters:
//   AW       word-address width (array holds 2^AW words)
//   LATENCY  edges from acceptance to completion, 1..15
// Ports:
//   clk      clock
//   rst      synchronous reset, active-high
//   dmem_io  data SRAM port (slave side), see dmem_responder_if
// Build option:
//   DMEM_RANGE_CHECK_EN  when defined, requests with addr bits above AW+1 set
//                        are out of range: writes are dropped, reads return 0
//                        and mem_err is set until reset. Otherwise addresses
//                        alias and mem_err is tied low.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int unsigned AW      = DMEM_AW,
   parameter int unsigned LATENCY = 1
) (
   input  logic              clk,
   input  logic              rst,
   dmem_responder_if.slave   dmem_io
);

   // Counter preload on acceptance; unused when LATENCY == 1.
   localparam logic [3:0] CntInit = 4'(LATENCY - 1);

   state_e               state_q, state_d;
   logic [3:0]           cnt_q, cnt_d;
   logic [NUM_LANES-1:0] wen_q, wen_d;
   logic [31:0]          addr_q, addr_d;
   logic [WORD_W-1:0]    wdata_q, wdata_d;
   logic                 stall;

   // The access actually performed this edge.
   logic                 acc_fire;
   logic [NUM_LANES-1:0] acc_wen;
   logic [31:0]          acc_addr;
   logic [WORD_W-1:0]    acc_wdata;
   logic                 acc_oor;

   logic [NUM_LANES-1:0] bank_we;
   logic                 bank_re;

   // ---------------------------------------------------------------------
   // FSM and request capture
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wen_d   = wen_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      stall   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (dmem_io.data_sram_en && (LATENCY > 1)) begin
               stall   = 1'b1;
               cnt_d   = CntInit;
               wen_d   = dmem_io.data_sram_wen;
               addr_d  = dmem_io.data_sram_addr;
               wdata_d = dmem_io.data_sram_wdata;
               state_d = StBusy;
            end
         end
         StBusy: begin
            stall = 1'b1;
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = StDone;
            end
         end
         StDone: begin
            // Requester still presents the finished request here; ignore it.
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         wen_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wen_q   <= wen_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   // ---------------------------------------------------------------------
   // Access selection: single-cycle builds use the live port, multi-cycle
   // builds use only the captured request.
   // ---------------------------------------------------------------------
   always_comb begin
      if (LATENCY == 1) begin
         acc_fire  = (state_q == StIdle) && dmem_io.data_sram_en;
         acc_wen   = dmem_io.data_sram_wen;
         acc_addr  = dmem_io.data_sram_addr;
         acc_wdata = dmem_io.data_sram_wdata;
      end else begin
         acc_fire  = (state_q == StBusy) && (cnt_q == 4'd1);
         acc_wen   = wen_q;
         acc_addr  = addr_q;
         acc_wdata = wdata_q;
      end
      // Reset aborts an in-flight access, including its write.
      if (rst) begin
         acc_fire = 1'b0;
      end
   end

`ifdef DMEM_RANGE_CHECK_EN
   logic err_q, err_d;

   assign acc_oor = (acc_addr >> (AW + 2)) != 32'd0;
   assign err_d   = err_q | (acc_fire & acc_oor);

   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign dmem_io.mem_err = err_q;
`else
   assign acc_oor         = 1'b0;
   assign dmem_io.mem_err = 1'b0;
`endif

   // Byte offset and (when aliasing) upper address bits do not select a word.
   logic unused_acc_addr;
   assign unused_acc_addr = ^acc_addr;

   assign bank_we = (acc_fire && !acc_oor) ? acc_wen : '0;
   assign bank_re = acc_fire && (acc_wen == '0);

   dmem_bank #(
      .AW (AW)
   ) u_bank (
      .clk       (clk),
      .rst       (rst),
      .we_i      (bank_we),
      .re_i      (bank_re),
      .rd_zero_i (acc_oor),
      .idx_i     (acc_addr[AW+1:2]),
      .wdata_i   (acc_wdata),
      .rdata_o   (dmem_io.data_sram_rdata)
   );

   assign dmem_io.stallreq_for_mem = stall;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LATENCY=1 instance driven from a vector table
// and a LATENCY=4 instance driven by hand-written multi-cycle sequences.
// Expected read data flows through a scoreboard queue.
module tb_dmem_responder;

   logic clk;
   logic rst;

   dmem_responder_if bus1 ();
   dmem_responder_if bus4 ();

   dmem_responder #(
      .AW      (12),
      .LATENCY (1)
   ) u_dut1 (
      .clk     (clk),
      .rst     (rst),
      .dmem_io (bus1.slave)
   );

   dmem_responder #(
      .AW      (12),
      .LATENCY (4)
   ) u_dut4 (
      .clk     (clk),
      .rst     (rst),
      .dmem_io (bus4.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   logic [31:0] sb_q [$];

   typedef struct packed {
      logic        en;
      logic [3:0]  wen;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs [11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // One complete access on the LATENCY=4 instance. Request is held through
   // DONE; optionally the port is changed after the first BUSY edge.
   task automatic acc4(input string name, input logic [3:0] wen, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit chg, input logic [31:0] addr2,
                       input logic [31:0] wdata2, input logic [31:0] exp_rd);
      int stalls;
      logic [31:0] want;
      stalls = 0;
      if (wen == 4'h0) sb_q.push_back(exp_rd);
      bus4.data_sram_en    = 1'b1;
      bus4.data_sram_wen   = wen;
      bus4.data_sram_addr  = addr;
      bus4.data_sram_wdata = wdata;
      #1;
      for (int i = 0; i < 20; i++) begin
         if (!bus4.stallreq_for_mem) break;
         stalls++;
         @(posedge clk);
         #1;
         if (chg && i == 0) begin
            bus4.data_sram_addr  = addr2;
            bus4.data_sram_wdata = wdata2;
            #1;
         end
      end
      check({name, " stall cycles"}, 32'(stalls), 32'd4);
      if (wen == 4'h0) begin
         want = sb_q.pop_front();
         check({name, " rdata in DONE"}, bus4.data_sram_rdata, want);
      end
      @(posedge clk);
      #1;
      bus4.data_sram_en = 1'b0;
      #1;
      check({name, " DONE ignores en"}, {31'd0, bus4.stallreq_for_mem}, 32'd0);
   endtask

   initial begin
      logic [31:0] want;

      //              en    wen    addr          wdata         rdata after edge
      vecs[0]  = '{1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000};
      vecs[1]  = '{1'b1, 4'h0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF};
      vecs[2]  = '{1'b1, 4'h4, 32'h0000_0010, 32'h5555_5555, 32'hDEAD_BEEF};
      vecs[3]  = '{1'b1, 4'h0, 32'h0000_0012, 32'h0000_0000, 32'hDE55_BEEF};
      vecs[4]  = '{1'b1, 4'hF, 32'h0000_0014, 32'h0123_4567, 32'hDE55_BEEF};
      vecs[5]  = '{1'b1, 4'h1, 32'h0000_0014, 32'h0000_00AA, 32'hDE55_BEEF};
      vecs[6]  = '{1'b1, 4'h0, 32'h0000_0017, 32'h0000_0000, 32'h0123_45AA};
      vecs[7]  = '{1'b0, 4'h0, 32'h0000_0010, 32'h0000_0000, 32'h0123_45AA};
      vecs[8]  = '{1'b1, 4'h8, 32'h0000_0010, 32'h1100_0000, 32'h0123_45AA};
      vecs[9]  = '{1'b1, 4'h0, 32'h0000_0010, 32'h0000_0000, 32'h1155_BEEF};
      vecs[10] = '{1'b1, 4'h0, 32'h0000_0014, 32'h0000_0000, 32'h0123_45AA};

      rst = 1'b1;
      bus1.data_sram_en = 1'b0; bus1.data_sram_wen = '0;
      bus1.data_sram_addr = '0; bus1.data_sram_wdata = '0;
      bus4.data_sram_en = 1'b0; bus4.data_sram_wen = '0;
      bus4.data_sram_addr = '0; bus4.data_sram_wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset rdata L1", bus1.data_sram_rdata, 32'd0);
      check("reset stall L1", {31'd0, bus1.stallreq_for_mem}, 32'd0);
      check("reset err L1", {31'd0, bus1.mem_err}, 32'd0);
      check("reset rdata L4", bus4.data_sram_rdata, 32'd0);
      check("reset stall L4", {31'd0, bus4.stallreq_for_mem}, 32'd0);
      check("reset err L4", {31'd0, bus4.mem_err}, 32'd0);
      rst = 1'b0;

      // LATENCY=1 vector table
      for (int i = 0; i < 11; i++) begin
         bus1.data_sram_en    = vecs[i].en;
         bus1.data_sram_wen   = vecs[i].wen;
         bus1.data_sram_addr  = vecs[i].addr;
         bus1.data_sram_wdata = vecs[i].wdata;
         sb_q.push_back(vecs[i].exp_rdata);
         #1;
         check($sformatf("L1 vec%0d stall", i), {31'd0, bus1.stallreq_for_mem}, 32'd0);
         @(posedge clk);
         #1;
         want = sb_q.pop_front();
         check($sformatf("L1 vec%0d rdata", i), bus1.data_sram_rdata, want);
      end
      bus1.data_sram_en = 1'b0;
      check("L1 err", {31'd0, bus1.mem_err}, 32'd0);

      // LATENCY=4: preload, then read with en held through DONE
      acc4("L4 wr20", 4'hF, 32'h20, 32'hCAFE_F00D, 1'b0, 32'h0, 32'h0, 32'h0);
      acc4("L4 wr30", 4'hF, 32'h30, 32'h0BAD_C0DE, 1'b0, 32'h0, 32'h0, 32'h0);
      acc4("L4 wr40", 4'hF, 32'h40, 32'h4040_4040, 1'b0, 32'h0, 32'h0, 32'h0);
      acc4("L4 wr44", 4'hF, 32'h44, 32'h4444_4444, 1'b0, 32'h0, 32'h0, 32'h0);
      acc4("L4 rd20", 4'h0, 32'h20, 32'h0, 1'b0, 32'h0, 32'h0, 32'hCAFE_F00D);

      // Port changes mid-BUSY must not redirect the captured write
      acc4("L4 wr40 chg", 4'hF, 32'h40, 32'h9999_9999, 1'b1, 32'h44, 32'h7777_7777, 32'h0);
      acc4("L4 rd40", 4'h0, 32'h40, 32'h0, 1'b0, 32'h0, 32'h0, 32'h9999_9999);
      acc4("L4 rd44", 4'h0, 32'h44, 32'h0, 1'b0, 32'h0, 32'h0, 32'h4444_4444);

      // Reset in the second BUSY cycle of a write aborts it
      bus4.data_sram_en    = 1'b1;
      bus4.data_sram_wen   = 4'hF;
      bus4.data_sram_addr  = 32'h30;
      bus4.data_sram_wdata = 32'h1234_5678;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      check("abort stall in BUSY", {31'd0, bus4.stallreq_for_mem}, 32'd1);
      rst = 1'b1;
      bus4.data_sram_en = 1'b0;
      @(posedge clk);
      #1;
      check("abort stall after rst", {31'd0, bus4.stallreq_for_mem}, 32'd0);
      check("abort rdata after rst", bus4.data_sram_rdata, 32'd0);
      rst = 1'b0;
      acc4("L4 rd30 after abort", 4'h0, 32'h30, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0BAD_C0DE);

      // Address above the array range
      acc4("L4 wr0", 4'hF, 32'h0, 32'h1357_9BDF, 1'b0, 32'h0, 32'h0, 32'h0);
      acc4("L4 wr oor", 4'hF, 32'h0001_0000, 32'hA5A5_A5A5, 1'b0, 32'h0, 32'h0, 32'h0);
`ifdef DMEM_RANGE_CHECK_EN
      check("oor err after write", {31'd0, bus4.mem_err}, 32'd1);
      repeat (10) @(posedge clk);
      #1;
      check("oor err sticky", {31'd0, bus4.mem_err}, 32'd1);
      acc4("L4 rd oor", 4'h0, 32'h0001_0000, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0);
      acc4("L4 rd0 intact", 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h1357_9BDF);
`else
      check("alias err after write", {31'd0, bus4.mem_err}, 32'd0);
      repeat (10) @(posedge clk);
      #1;
      check("alias err idle", {31'd0, bus4.mem_err}, 32'd0);
      acc4("L4 rd alias", 4'h0, 32'h0001_0000, 32'h0, 1'b0, 32'h0, 32'h0, 32'hA5A5_A5A5);
      acc4("L4 rd0 aliased", 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 32'hA5A5_A5A5);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1);
   end

endmodule
